// File: rtl/ball_collision_ctrl.sv
// Collision write scheduler for the billiard ball units.
// Wall reflections and equal-mass pair swaps are sent over one shared velocity bus.
module ball_collision_ctrl #(
  parameter int NUM_BALLS = 4,
  parameter int IDX_W     = $clog2(NUM_BALLS)
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic [NUM_BALLS-1:0]     wallHitX,
  input  logic [NUM_BALLS-1:0]     wallHitY,
  input  logic [NUM_BALLS*11-1:0]  velX_in,
  input  logic [NUM_BALLS*11-1:0]  velY_in,
  input  logic                     pairReq,
  input  logic [IDX_W-1:0]         pairA,
  input  logic [IDX_W-1:0]         pairB,
  output logic                     pairAck,
  output logic [NUM_BALLS-1:0]     velocityWriteEnable,
  output logic signed [10:0]       outVelocityX,
  output logic signed [10:0]       outVelocityY,
  output logic                     busy
);

  localparam int NSLOT = 1 << IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    WALL_WR,
    PAIR_CAP,
    PAIR_WR_A,
    PAIR_WR_B,
    PAIR_ACK
  } state_t;

  state_t state;

  logic [NUM_BALLS-1:0] pendX;
  logic [NUM_BALLS-1:0] pendY;
  logic [NUM_BALLS-1:0] mask;
  logic [NUM_BALLS-1:0] pendXNx;
  logic [NUM_BALLS-1:0] pendYNx;
  logic [NUM_BALLS-1:0] maskNx;
  logic [NUM_BALLS-1:0] pendAny;

  logic [IDX_W-1:0] wIdx;
  logic [IDX_W-1:0] aIdx;
  logic [IDX_W-1:0] bIdx;
  logic [IDX_W-1:0] lowIdx;

  logic signed [10:0] vAx;
  logic signed [10:0] vAy;
  logic signed [10:0] vBx;
  logic signed [10:0] vBy;

  logic signed [10:0] vx [NSLOT];
  logic signed [10:0] vy [NSLOT];
  logic [NSLOT-1:0]   slotOk;
  logic [NSLOT-1:0]   maskExt;

  logic wrGo;
  logic wallWr;
  logic wrA;
  logic wrB;
  logic pairBad;

  function automatic logic signed [10:0] satNeg(
    input logic signed [10:0] v
  );
    return (v == -11'sd1024) ? 11'sd1023 : -v;
  endfunction

  function automatic logic [NUM_BALLS-1:0] sel(
    input logic [IDX_W-1:0] i
  );
    return NUM_BALLS'(1) << i;
  endfunction

  // Pad per-ball views to a power of two so any index is safe to look up.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      vx[i]      = '0;
      vy[i]      = '0;
      slotOk[i]  = 1'b0;
      maskExt[i] = 1'b0;
    end
    for (int i = 0; i < NUM_BALLS; i++) begin
      vx[i]      = velX_in[11*i +: 11];
      vy[i]      = velY_in[11*i +: 11];
      slotOk[i]  = 1'b1;
      maskExt[i] = mask[i];
    end
  end

  assign pendAny = pendX | pendY;

  always_comb begin
    lowIdx = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (pendAny[i]) lowIdx = IDX_W'(i);
    end
  end

  assign pairBad = (pairA == pairB)
                 | ~slotOk[pairA]
                 | ~slotOk[pairB]
                 | maskExt[pairA]
                 | maskExt[pairB];

  assign wrGo   = ~startOfFrame;
  assign wallWr = (state == WALL_WR)   & wrGo;
  assign wrA    = (state == PAIR_WR_A) & wrGo;
  assign wrB    = (state == PAIR_WR_B) & wrGo;

  assign pairAck = (state == PAIR_ACK);
  assign busy    = (state != IDLE);

  always_comb begin
    velocityWriteEnable = '0;
    outVelocityX        = '0;
    outVelocityY        = '0;
    unique case (1'b1)
      wallWr: begin
        velocityWriteEnable = sel(wIdx);
        outVelocityX = pendX[wIdx] ? satNeg(vx[wIdx]) : vx[wIdx];
        outVelocityY = pendY[wIdx] ? satNeg(vy[wIdx]) : vy[wIdx];
      end
      wrA: begin
        velocityWriteEnable = sel(aIdx);
        outVelocityX = vBx;
        outVelocityY = vBy;
      end
      wrB: begin
        velocityWriteEnable = sel(bIdx);
        outVelocityX = vAx;
        outVelocityY = vAy;
      end
      default: ;
    endcase
  end

  // A write's clear beats a same-cycle hit; a mask set beats the frame clear.
  always_comb begin
    pendXNx = pendX | (wallHitX & ~mask);
    pendYNx = pendY | (wallHitY & ~mask);
    maskNx  = startOfFrame ? '0 : mask;
    if (wallWr) begin
      pendXNx = pendXNx & ~sel(wIdx);
      pendYNx = pendYNx & ~sel(wIdx);
      maskNx  = maskNx | sel(wIdx);
    end
    if (wrB) begin
      maskNx = maskNx | sel(aIdx) | sel(bIdx);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      pendX <= '0;
      pendY <= '0;
      mask  <= '0;
      wIdx  <= '0;
      aIdx  <= '0;
      bIdx  <= '0;
      vAx   <= '0;
      vAy   <= '0;
      vBx   <= '0;
      vBy   <= '0;
    end else begin
      pendX <= pendXNx;
      pendY <= pendYNx;
      mask  <= maskNx;
      unique case (state)
        IDLE: begin
          if (|pendAny) begin
            wIdx  <= lowIdx;
            state <= WALL_WR;
          end else if (pairReq && pairBad) begin
            state <= PAIR_ACK;
          end else if (pairReq) begin
            state <= PAIR_CAP;
          end
        end
        WALL_WR: begin
          if (wrGo) state <= IDLE;
        end
        PAIR_CAP: begin
          aIdx  <= pairA;
          bIdx  <= pairB;
          vAx   <= vx[pairA];
          vAy   <= vy[pairA];
          vBx   <= vx[pairB];
          vBy   <= vy[pairB];
          state <= PAIR_WR_A;
        end
        PAIR_WR_A: begin
          if (wrGo) state <= PAIR_WR_B;
        end
        PAIR_WR_B: begin
          if (wrGo) state <= PAIR_ACK;
        end
        PAIR_ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_collision_ctrl.sv
// Bench for ball_collision_ctrl: directed scenarios plus random traffic
// against a job-queue reference model.
module tb_ball_collision_ctrl;

  localparam int N  = 4;
  localparam int IW = 2;

  localparam int K_WALL = 0;
  localparam int K_CAP  = 1;
  localparam int K_WA   = 2;
  localparam int K_WB   = 3;
  localparam int K_ACK  = 4;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              sof = 1'b0;
  logic [N-1:0]      hx = '0;
  logic [N-1:0]      hy = '0;
  logic [N*11-1:0]   vxin = '0;
  logic [N*11-1:0]   vyin = '0;
  logic              req = 1'b0;
  logic [IW-1:0]     pa = '0;
  logic [IW-1:0]     pb = '0;

  logic               pairAck;
  logic [N-1:0]       we;
  logic signed [10:0] ox;
  logic signed [10:0] oy;
  logic               busy;

  ball_collision_ctrl #(.NUM_BALLS(N)) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (sof),
    .wallHitX            (hx),
    .wallHitY            (hy),
    .velX_in             (vxin),
    .velY_in             (vyin),
    .pairReq             (req),
    .pairA               (pa),
    .pairB               (pb),
    .pairAck             (pairAck),
    .velocityWriteEnable (we),
    .outVelocityX        (ox),
    .outVelocityY        (oy),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  bit mpx [N];
  bit mpy [N];
  bit mm  [N];
  int q [$];
  int qw, cA, cB;
  int vAx, vAy, vBx, vBy;

  bit           eack, ebusy;
  logic [N-1:0] ewe;
  int           ex, ey;

  logic [N-1:0] lw;
  int           lx, ly;
  logic         lack, lbusy;

  function automatic int sx(input logic [N*11-1:0] v, input int i);
    logic signed [10:0] t;
    t = v[11*i +: 11];
    return int'(t);
  endfunction

  function automatic int sneg(input int v);
    int r;
    r = -v;
    if (r > 1023) r = 1023;
    return r;
  endfunction

  task automatic setv(input int i, input int x, input int y);
    vxin[11*i +: 11] = 11'(x);
    vyin[11*i +: 11] = 11'(y);
  endtask

  task automatic model_step();
    bit setm [N];
    bit clrp [N];
    int low;
    eack = 0; ebusy = 0; ewe = '0; ex = 0; ey = 0;
    for (int i = 0; i < N; i++) begin
      setm[i] = 0;
      clrp[i] = 0;
    end
    if (!resetN) begin
      for (int i = 0; i < N; i++) begin
        mpx[i] = 0; mpy[i] = 0; mm[i] = 0;
      end
      q.delete();
      return;
    end
    ebusy = (q.size() != 0);
    if (q.size() == 0) begin
      low = -1;
      for (int i = N - 1; i >= 0; i--)
        if (mpx[i] || mpy[i]) low = i;
      if (low >= 0) begin
        qw = low;
        q.push_back(K_WALL);
      end else if (req) begin
        if (pa == pb || mm[pa] || mm[pb]) q.push_back(K_ACK);
        else q = {K_CAP, K_WA, K_WB, K_ACK};
      end
    end else begin
      case (q[0])
        K_CAP: begin
          cA = pa; cB = pb;
          vAx = sx(vxin, cA); vAy = sx(vyin, cA);
          vBx = sx(vxin, cB); vBy = sx(vyin, cB);
          void'(q.pop_front());
        end
        K_WALL: if (!sof) begin
          ewe[qw] = 1'b1;
          ex = mpx[qw] ? sneg(sx(vxin, qw)) : sx(vxin, qw);
          ey = mpy[qw] ? sneg(sx(vyin, qw)) : sx(vyin, qw);
          clrp[qw] = 1; setm[qw] = 1;
          void'(q.pop_front());
        end
        K_WA: if (!sof) begin
          ewe[cA] = 1'b1; ex = vBx; ey = vBy;
          void'(q.pop_front());
        end
        K_WB: if (!sof) begin
          ewe[cB] = 1'b1; ex = vAx; ey = vAy;
          setm[cA] = 1; setm[cB] = 1;
          void'(q.pop_front());
        end
        default: begin
          eack = 1;
          void'(q.pop_front());
        end
      endcase
    end
    for (int i = 0; i < N; i++) begin
      mpx[i] = (mpx[i] | (hx[i] & !mm[i])) & !clrp[i];
      mpy[i] = (mpy[i] | (hy[i] & !mm[i])) & !clrp[i];
      mm[i]  = (sof ? 1'b0 : mm[i]) | setm[i];
    end
  endtask

  task automatic cyc();
    logic [27:0] g, e;
    #3;
    model_step();
    g = {pairAck, busy, we, ox, oy};
    e = {eack, ebusy, ewe, 11'(ex), 11'(ey)};
    check($sformatf("cycle%0d", ncyc), 64'(g), 64'(e));
    check("onehot", 64'($onehot0(we)), 64'd1);
    lw = we; lx = int'(ox); ly = int'(oy);
    lack = pairAck; lbusy = busy;
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic int rvel();
    if ($urandom_range(0, 9) == 0) return -1024;
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  initial begin
    @(posedge clk);
    #1;
    cyc();
    cyc();
    check("reset_we", 64'(lw), 64'd0);
    check("reset_busy", 64'(lbusy), 64'd0);
    check("reset_ack", 64'(lack), 64'd0);
    resetN = 1'b1;
    cyc();

    setv(2, 37, -5);
    hx = 4'b0100; cyc();
    hx = '0; cyc();
    cyc();
    check("t1_we", 64'(lw), 64'b0100);
    check("t1_x", 64'(lx), 64'(-37));
    check("t1_y", 64'(ly), 64'(-5));
    hx = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) hx = '0;
      cyc();
      check("t1_masked", 64'(lw), 64'd0);
    end

    setv(1, 10, 12); setv(3, -7, 3);
    hy = 4'b0010; hx = 4'b1000; cyc();
    hx = '0; hy = '0; cyc();
    cyc();
    check("t2_we1", 64'(lw), 64'b0010);
    check("t2_x1", 64'(lx), 64'(10));
    check("t2_y1", 64'(ly), 64'(-12));
    cyc();
    cyc();
    check("t2_we3", 64'(lw), 64'b1000);
    check("t2_x3", 64'(lx), 64'(7));
    check("t2_y3", 64'(ly), 64'(3));

    sof = 1; cyc(); sof = 0;
    setv(0, 20, 8); setv(3, -4, 0);
    pa = 0; pb = 3; req = 1;
    cyc(); cyc(); cyc();
    check("t3_weA", 64'(lw), 64'b0001);
    check("t3_xA", 64'(lx), 64'(-4));
    check("t3_yA", 64'(ly), 64'(0));
    cyc();
    check("t3_weB", 64'(lw), 64'b1000);
    check("t3_xB", 64'(lx), 64'(20));
    check("t3_yB", 64'(ly), 64'(8));
    cyc();
    check("t3_ack", 64'(lack), 64'd1);
    req = 0; cyc();
    check("t3_ack_once", 64'(lack), 64'd0);

    sof = 1; cyc(); sof = 0;
    req = 1; cyc(); cyc();
    sof = 1; cyc();
    check("t4_stall", 64'(lw), 64'd0);
    sof = 0; cyc();
    check("t4_weA", 64'(lw), 64'b0001);
    check("t4_xA", 64'(lx), 64'(-4));
    cyc();
    check("t4_weB", 64'(lw), 64'b1000);
    check("t4_yB", 64'(ly), 64'(8));
    cyc();
    check("t4_ack", 64'(lack), 64'd1);
    req = 0; cyc();

    pa = 1; pb = 1; req = 1; cyc(); cyc();
    check("t5_same_ack", 64'(lack), 64'd1);
    check("t5_same_we", 64'(lw), 64'd0);
    req = 0; cyc();
    pa = 0; pb = 1; req = 1; cyc(); cyc();
    check("t5_mask_ack", 64'(lack), 64'd1);
    check("t5_mask_we", 64'(lw), 64'd0);
    req = 0; cyc();
    sof = 1; cyc(); sof = 0;
    req = 1; cyc(); cyc(); cyc();
    check("t5_weA", 64'(lw), 64'b0001);
    check("t5_xA", 64'(lx), 64'(10));
    cyc();
    check("t5_weB", 64'(lw), 64'b0010);
    check("t5_xB", 64'(lx), 64'(20));
    cyc();
    check("t5_ack", 64'(lack), 64'd1);
    req = 0; cyc();

    sof = 1; cyc(); sof = 0;
    setv(0, -1024, 5);
    hx = 4'b0001; cyc();
    hx = '0; cyc(); cyc();
    check("t6_we", 64'(lw), 64'b0001);
    check("t6_sat", 64'(lx), 64'(1023));
    check("t6_y", 64'(ly), 64'(5));
    pa = 1; pb = 2; req = 1;
    cyc(); cyc(); cyc();
    resetN = 0; cyc();
    check("t6_rst_we", 64'(lw), 64'd0);
    check("t6_rst_busy", 64'(lbusy), 64'd0);
    check("t6_rst_x", 64'(lx), 64'd0);
    resetN = 1; req = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("t6_noack", 64'(lack), 64'd0);
    end

    for (int k = 0; k < 3000; k++) begin
      sof    = ($urandom_range(0, 11) == 0);
      hx     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      hy     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      resetN = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) setv(i, rvel(), rvel());
      if (eack) req = 0;
      if (!req && $urandom_range(0, 5) == 0) begin
        req = 1;
        pa  = 2'($urandom);
        pb  = 2'($urandom);
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
